// File: rtl/signed_ramp_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_ramp_gen_if
// Description : Control and valid/ready sample bus between the signed ramp
//               producer and its controller/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_ramp_gen_if #(
    parameter int WIDTH = 8
);
    // Controller -> producer
    logic                    start;
    logic signed [WIDTH-1:0] start_val;
    logic signed [WIDTH-1:0] end_val;
    logic                    abort;
    // Consumer -> producer
    logic                    ready;
    // Producer -> consumer / controller
    logic                    valid;
    logic signed [WIDTH-1:0] data;
    logic                    neg;
    logic                    busy;
    logic                    done;

    // Ramp generator side
    modport master (
        input  start,
        input  start_val,
        input  end_val,
        input  abort,
        input  ready,
        output valid,
        output data,
        output neg,
        output busy,
        output done
    );

    // Controller / sample consumer side
    modport slave (
        output start,
        output start_val,
        output end_val,
        output abort,
        output ready,
        input  valid,
        input  data,
        input  neg,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/signed_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module      : signed_ramp_gen
// Description : Programmable signed ramp producer. Emits start_val..end_val
//               in steps of STEP, one sample per valid/ready handshake, with
//               a registered sign flag. Never wraps and never overshoots the
//               end value.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_ramp_gen #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    signed_ramp_gen_if.master bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_fin  = 2'd2;

    // Step magnitude held one bit wider than a sample so that DATA +/- STEP
    // can be formed without overflow at either end of the signed range.
    localparam logic signed [WIDTH:0] c_step = (WIDTH + 1)'(STEP);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]              r_state;
    logic                    r_down;    // sweep direction latched at start
    logic signed [WIDTH-1:0] r_end;     // limit sample latched at start
    logic signed [WIDTH-1:0] r_data;    // current sample
    logic                    r_valid;   // sample on the bus

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic signed [WIDTH:0]   w_data_ext;
    logic signed [WIDTH:0]   w_end_ext;
    logic signed [WIDTH:0]   w_next;
    logic                    w_past_end;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_start_down;

    assign w_data_ext   = {r_data[WIDTH-1], r_data};
    assign w_end_ext    = {r_end[WIDTH-1], r_end};

    // Candidate next sample in the widened domain; it is only loaded back
    // into r_data when it does not pass the end value, so it always fits.
    assign w_next       = r_down ? (w_data_ext - c_step) : (w_data_ext + c_step);

    assign w_past_end   = r_down ? (w_next < w_end_ext) : (w_next > w_end_ext);
    assign w_last       = (r_data == r_end) || w_past_end;

    assign w_accept     = r_valid && bus.ready;

    // Descending sweep when the first sample is strictly above the limit.
    assign w_start_down = (bus.start_val > bus.end_val);

    // ------------------------------------------------------------------------
    // Sweep control FSM and sample register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_down  <= 1'b0;
            r_end   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_state <= c_run;
                        r_down  <= w_start_down;
                        r_end   <= bus.end_val;
                        r_data  <= bus.start_val;
                        r_valid <= 1'b1;
                    end
                end

                c_run: begin
                    // Abort wins over a coincident handshake; the sample on
                    // the bus that cycle is treated as never delivered.
                    if (bus.abort) begin
                        r_state <= c_fin;
                        r_data  <= '0;
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_state <= c_fin;
                            r_data  <= '0;
                            r_valid <= 1'b0;
                        end else begin
                            r_data  <= w_next[WIDTH-1:0];
                        end
                    end
                end

                c_fin: begin
                    // One-cycle completion state; start requests are ignored.
                    r_state <= c_idle;
                end

                default: begin
                    r_state <= c_idle;
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived directly from registers
    // ------------------------------------------------------------------------
    assign bus.valid = r_valid;
    assign bus.data  = r_data;
    assign bus.neg   = r_data[WIDTH-1];
    assign bus.busy  = (r_state == c_run);
    assign bus.done  = (r_state == c_fin);

endmodule
`default_nettype wire

// File: tb/tb_signed_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_ramp_gen
// Description : Self-checking bench for signed_ramp_gen. Three instances
//               (STEP = 1, 2, 4) share stimulus; one is selected per sweep.
//               Expected sample streams come from a simple arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_ramp_gen;

    localparam int WIDTH = 8;

    typedef struct {
        int step;       // selects the instance with this STEP
        int s;          // start value
        int e;          // end value
        int rdy;        // 0: ready always, 1: random, 2: pattern 1,0,0,1
        int abort_idx;  // abort when this sample index is presented, -1 none
        int poke;       // issue ignored start requests during RUN and FIN
        int exp_cnt;    // expected accepted samples, -1 = take from model
        int exp_last;   // expected last accepted sample
    } vec_t;

    logic clk;
    logic rst;
    logic start;
    logic signed [WIDTH-1:0] start_val;
    logic signed [WIDTH-1:0] end_val;
    logic abort;
    logic ready;
    int   sel;

    logic o_valid;
    logic signed [WIDTH-1:0] o_data;
    logic o_neg;
    logic o_busy;
    logic o_done;

    int n_checks;
    int n_err;
    int pat [4] = '{1, 0, 0, 1};

    signed_ramp_gen_if #(.WIDTH(WIDTH)) bus1 ();
    signed_ramp_gen_if #(.WIDTH(WIDTH)) bus2 ();
    signed_ramp_gen_if #(.WIDTH(WIDTH)) bus4 ();

    assign bus1.start = start && (sel == 1);
    assign bus2.start = start && (sel == 2);
    assign bus4.start = start && (sel == 4);
    assign bus1.abort = abort && (sel == 1);
    assign bus2.abort = abort && (sel == 2);
    assign bus4.abort = abort && (sel == 4);
    assign bus1.start_val = start_val;
    assign bus2.start_val = start_val;
    assign bus4.start_val = start_val;
    assign bus1.end_val = end_val;
    assign bus2.end_val = end_val;
    assign bus4.end_val = end_val;
    assign bus1.ready = ready;
    assign bus2.ready = ready;
    assign bus4.ready = ready;

    signed_ramp_gen #(.WIDTH(WIDTH), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    signed_ramp_gen #(.WIDTH(WIDTH), .STEP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    signed_ramp_gen #(.WIDTH(WIDTH), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Observe the selected instance
    always_comb begin
        o_valid = bus1.valid;
        o_data  = bus1.data;
        o_neg   = bus1.neg;
        o_busy  = bus1.busy;
        o_done  = bus1.done;
        if (sel == 2) begin
            o_valid = bus2.valid;
            o_data  = bus2.data;
            o_neg   = bus2.neg;
            o_busy  = bus2.busy;
            o_done  = bus2.done;
        end else if (sel == 4) begin
            o_valid = bus4.valid;
            o_data  = bus4.data;
            o_neg   = bus4.neg;
            o_busy  = bus4.busy;
            o_done  = bus4.done;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic chk_idle_outputs(input string tag, input int exp_done);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_data"},  int'(o_data), 0);
        chk({tag, "_neg"},   int'(o_neg), 0);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_done"},  int'(o_done), exp_done);
    endtask

    // Run one sweep and compare every presented sample with the model stream
    task automatic run_vec(input vec_t v);
        int  exp_q [$];
        int  x;
        int  n_acc;
        int  last_acc;
        int  cyc;
        int  cnt_exp;
        int  last_exp;
        bit  fin;
        bit  abort_now;

        // Reference stream: plain arithmetic from start toward end, inclusive
        x = v.s;
        if (v.s <= v.e) begin
            while (x <= v.e) begin
                exp_q.push_back(x);
                x += v.step;
            end
        end else begin
            while (x >= v.e) begin
                exp_q.push_back(x);
                x -= v.step;
            end
        end
        if (v.abort_idx >= 0 && v.abort_idx < exp_q.size()) begin
            cnt_exp  = v.abort_idx;
            last_exp = (v.abort_idx > 0) ? exp_q[v.abort_idx - 1] : 0;
        end else begin
            cnt_exp  = exp_q.size();
            last_exp = exp_q[exp_q.size() - 1];
        end
        if (v.exp_cnt >= 0) begin
            cnt_exp  = v.exp_cnt;
            last_exp = v.exp_last;
        end

        sel = v.step;
        @(negedge clk);
        start     = 1'b1;
        start_val = WIDTH'(v.s);
        end_val   = WIDTH'(v.e);
        ready     = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        // Scramble the inputs: the sweep must run from its latched values
        start_val = WIDTH'($urandom);
        end_val   = WIDTH'($urandom);
        chk("first_valid", int'(o_valid), 1);

        n_acc    = 0;
        last_acc = 0;
        cyc      = 0;
        fin      = 1'b0;
        while (!fin) begin
            if (cyc >= 1000) begin
                fail_now("cycle_budget_expired");
                fin = 1'b1;
            end else if (o_valid !== 1'b1) begin
                chk("valid_high", int'(o_valid), 1);
                fin = 1'b1;
            end else begin
                chk("data", int'(o_data), exp_q[n_acc]);
                chk("neg", int'(o_neg), int'(exp_q[n_acc] < 0));
                chk("busy", int'(o_busy), 1);
                chk("done_low", int'(o_done), 0);
                case (v.rdy)
                    0:       ready = 1'b1;
                    1:       ready = 1'($urandom_range(0, 1));
                    default: ready = 1'(pat[cyc % 4]);
                endcase
                abort_now = (n_acc == v.abort_idx);
                if (abort_now) ready = 1'b1;
                abort = abort_now;
                if (v.poke != 0 && cyc == 1) begin
                    start     = 1'b1;
                    start_val = 8'sd0;
                    end_val   = 8'sd0;
                end
                x = int'(o_data);
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                if (abort_now) begin
                    fin = 1'b1;
                end else if (ready) begin
                    last_acc = x;
                    n_acc++;
                    if (n_acc >= exp_q.size()) fin = 1'b1;
                end
                cyc++;
            end
        end
        ready = 1'b0;

        // One cycle after the final handshake or abort: FIN with DONE
        chk_idle_outputs("fin", 1);
        if (v.poke != 0) begin
            start     = 1'b1;
            start_val = -8'sd5;
            end_val   = 8'sd5;
        end
        @(negedge clk);
        start = 1'b0;
        chk_idle_outputs("idle", 0);
        chk("count", n_acc, cnt_exp);
        chk("last", last_acc, last_exp);
    endtask

    initial begin
        vec_t vecs [$];
        vec_t r;
        int   steps [3] = '{1, 2, 4};

        // step, s, e, rdy, abort_idx, poke, exp_cnt, exp_last
        vecs.push_back('{1,   -5,   99, 0, -1, 0, 105,   99});
        vecs.push_back('{2,    3,   -3, 0, -1, 0,   4,   -3});
        vecs.push_back('{1, -128,  127, 0, -1, 0, 256,  127});
        vecs.push_back('{4,    0,   10, 0, -1, 0,   3,    8});
        vecs.push_back('{1,   -1,   -1, 0, -1, 1,   1,   -1});
        vecs.push_back('{1,   -2,    2, 2, -1, 0,   5,    2});
        vecs.push_back('{1,   -3,    3, 0,  2, 0,   2,   -2});
        vecs.push_back('{1,    4,    6, 0, -1, 0,   3,    6});
        vecs.push_back('{2,   -3,    4, 1, -1, 1,   4,    3});
        vecs.push_back('{4,  127, -128, 1, -1, 0,  64, -125});
        vecs.push_back('{2,  127, -128, 0, -1, 0, 128, -127});
        for (int i = 0; i < 8; i++) begin
            r.step      = steps[$urandom_range(0, 2)];
            r.s         = int'($urandom_range(0, 255)) - 128;
            r.e         = int'($urandom_range(0, 255)) - 128;
            r.rdy       = 1;
            r.abort_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            r.poke      = int'($urandom_range(0, 1));
            r.exp_cnt   = -1;
            r.exp_last  = 0;
            vecs.push_back(r);
        end

        n_checks  = 0;
        n_err     = 0;
        sel       = 1;
        rst       = 1'b1;
        start     = 1'b0;
        start_val = '0;
        end_val   = '0;
        abort     = 1'b0;
        ready     = 1'b0;

        #3;
        chk_idle_outputs("reset", 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset", 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of a sweep
        sel = 1;
        @(negedge clk);
        start     = 1'b1;
        start_val = -8'sd40;
        end_val   = 8'sd50;
        ready     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", int'(o_busy), 1);
        chk("pre_rst_neg", int'(o_neg), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst", 0);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_valid", int'(o_valid), 0);
            chk("rst_hold_busy", int'(o_busy), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle_outputs("after_rst", 0);
        end

        // A fresh sweep after reset must start cleanly
        run_vec('{1, -3, 3, 1, -1, 0, 7, 3});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
